absmax_sum_stream: RTL and testbench
====================================

Name: absmax_sum_stream

Overview:
- Multi-lane streaming reducer: per frame, computes the maximum absolute value, the signed sum and the beat count over LANES signed samples per beat.
- Hardware successor to the combinational add/max/abs/absmax helpers, generalised in sample width, lane count, lane masking and overflow mode.
- Sits between a sample source and the statistics/CSR block.
- Uses valid/ready handshakes on both sides.

Parameters:
N, 23, sample width in bits (signed two's complement)
LANES, 4, samples per input beat
SUMW, N+8, accumulator/result sum width (signed); must be >= N+clog2(LANES)
CNTW, 16, beat counter width
SAT, 0, 0 = sum wraps modulo 2^SUMW; 1 = sum saturates at signed min/max

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  LANES*N  lane k at bits [k*N +: N], signed
in_keep  input  LANES  lane k participates when 1
in_last  input  1  final beat of frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_absmax  output  N  max |sample| over kept lanes of frame, unsigned
out_sum  output  SUMW  signed sum over kept lanes of frame
out_count  output  CNTW  beats in frame (including keep=0 beats)
out_ovf  output  1  sum overflowed at least once in frame

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_absmax=0, out_sum=0, out_count=0, out_ovf=0; accumulators (acc_max, acc_sum, acc_cnt, acc_ovf) = 0. Reset mid-frame discards the partial frame; no result is emitted.
- in_ready = !out_valid | out_ready. This is combinational and in_ready has no other dependency. Beat accepted when in_valid & in_ready.
- Per-lane abs: |x| computed in N-bit unsigned. abs(-2^(N-1)) = 2^(N-1), exact, no saturation. Lanes with keep=0 contribute 0 to max and sum.
- Beat sum: sign-extend kept lanes to SUMW and add.
- New sum = acc_sum + beat sum, computed at SUMW+1 bits. Overflow when the result is outside the signed SUMW range. SAT=1: clamp to 2^(SUMW-1)-1 or -2^(SUMW-1). SAT=0: keep low SUMW bits. In both modes the frame ovf flag becomes sticky 1.
- Beat count: acc_cnt+1, saturating at 2^CNTW-1. Saturation does not set ovf.
- Accepted beat, in_last=0: accumulators update; no output change unless out_ready retires a result in the same cycle.
- Accepted beat, in_last=1: the combined result (accumulators including this beat) loads out_* registers. out_valid=1 on the next edge (latency 1 cycle from last-beat acceptance). Accumulators clear to 0 on that same edge.
- Single-beat frame (in_last on first beat): out_count=1.
- Output retire: out_valid & out_ready clears out_valid on the next edge unless a new last beat loads the outputs in the same cycle, in which case out_valid stays 1 with the new data (back-to-back, no bubble).
- out_* data registers hold the last result after retire. Consumers must sample only while out_valid=1.
- While out_valid=1 and out_ready=0: in_ready=0, accumulators frozen, out_* stable.
- No input-side FSM states beyond accumulating. The output side is a 1-entry skid-free holding register.

Test Plan:
- N=8,LANES=4,SUMW=16: one beat {3,-7,5,-2}, keep=4'hF, last=1 -> next cycle out_valid=1, absmax=7, sum=-1, count=1, ovf=0.
- Two beats {-128,1,1,1} then {10,20,30,40}, keep=4'hF, second last=1 -> absmax=128, sum=-25, count=2, ovf=0.
- Beat {100,-120,50,60}, keep=4'b0101, last=1 -> absmax=100, sum=150, count=1.
- SUMW=9, SAT=1: 3 beats {127,127,127,127} -> sum=255, ovf=1. SUMW=9, SAT=0, same stimulus -> sum=(1524 mod 512 as signed 9-bit)=-12, ovf=1.
- out_ready=0 for 5 cycles after a result -> in_ready=0, outputs stable, new last-beat held upstream. Then out_ready=1 with a pending last beat -> out_valid stays 1, new result loaded with no gap.
- Assert rst_n=0 after 2 non-last beats, release, send one beat {1,1,1,1} last -> sum=4, count=1 (partial frame discarded, no spurious out_valid).

Source files
------------

// File: rtl/absmax_sum_stream.sv
// Multi-lane streaming reducer: per frame, tracks the max |sample|, the signed
// sum (wrapping or saturating) and the beat count, then presents the result in
// a one-entry output register with a valid/ready handshake.
module absmax_sum_stream #(
    parameter int unsigned N     = 23,
    parameter int unsigned LANES = 4,
    parameter int unsigned SUMW  = N + 8,
    parameter int unsigned CNTW  = 16,
    parameter bit          SAT   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*N-1:0]   in_data,
    input  logic [LANES-1:0]     in_keep,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_absmax,
    output logic [SUMW-1:0]      out_sum,
    output logic [CNTW-1:0]      out_count,
    output logic                 out_ovf
);

    // Wide enough to hold acc_sum plus a full beat exactly, even if the beat
    // sum alone would not fit in SUMW bits.
    localparam int unsigned WW = SUMW + $clog2(LANES) + 2;

    localparam logic [SUMW-1:0] SumMax = {1'b0, {(SUMW-1){1'b1}}};
    localparam logic [SUMW-1:0] SumMin = {1'b1, {(SUMW-1){1'b0}}};

    logic [N-1:0]    acc_max_q;
    logic [SUMW-1:0] acc_sum_q;
    logic [CNTW-1:0] acc_cnt_q;
    logic            acc_ovf_q;

    logic [N-1:0]    lane_mag [LANES];
    logic [WW-1:0]   lane_ext [LANES];

    logic [N-1:0]    beat_max;
    logic [WW-1:0]   beat_sum;
    logic [WW-1:0]   sum_wide;
    logic            sum_ovf;
    logic [N-1:0]    max_next;
    logic [SUMW-1:0] sum_next;
    logic [CNTW-1:0] cnt_next;
    logic            ovf_next;
    logic            accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Per-lane magnitude and sign extension; masked lanes contribute zero.
    // Negating the most negative value yields 2^(N-1), exact when read unsigned.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [N-1:0] x;
        assign x           = in_data[k*N +: N];
        assign lane_mag[k] = in_keep[k] ? (x[N-1] ? -x : x) : '0;
        assign lane_ext[k] = in_keep[k] ? {{(WW-N){x[N-1]}}, x} : '0;
    end

    // Reduce the lanes of the current beat to one max and one sum.
    always_comb begin
        beat_max = '0;
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane_mag[k] > beat_max) begin
                beat_max = lane_mag[k];
            end
            beat_sum = beat_sum + lane_ext[k];
        end
    end

    // Combine the beat with the running accumulators.
    always_comb begin
        sum_wide = {{(WW-SUMW){acc_sum_q[SUMW-1]}}, acc_sum_q} + beat_sum;
        // In range only if all bits from the SUMW sign bit upward agree.
        sum_ovf  = !((&sum_wide[WW-1:SUMW-1]) || !(|sum_wide[WW-1:SUMW-1]));
        sum_next = sum_wide[SUMW-1:0];
        if (SAT && sum_ovf) begin
            sum_next = sum_wide[WW-1] ? SumMin : SumMax;
        end
        max_next = (beat_max > acc_max_q) ? beat_max : acc_max_q;
        cnt_next = (&acc_cnt_q) ? acc_cnt_q : acc_cnt_q + CNTW'(1);
        ovf_next = acc_ovf_q || sum_ovf;
    end

    // Accumulators: update on every accepted beat, clear once the frame closes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_max_q <= '0;
            acc_sum_q <= '0;
            acc_cnt_q <= '0;
            acc_ovf_q <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                acc_max_q <= '0;
                acc_sum_q <= '0;
                acc_cnt_q <= '0;
                acc_ovf_q <= 1'b0;
            end else begin
                acc_max_q <= max_next;
                acc_sum_q <= sum_next;
                acc_cnt_q <= cnt_next;
                acc_ovf_q <= ovf_next;
            end
        end
    end

    // Output holding register: a closing beat loads it (even while a retire
    // happens the same cycle); a retire without a new result drops valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_absmax <= '0;
            out_sum    <= '0;
            out_count  <= '0;
            out_ovf    <= 1'b0;
        end else if (accept && in_last) begin
            out_valid  <= 1'b1;
            out_absmax <= max_next;
            out_sum    <= sum_next;
            out_count  <= cnt_next;
            out_ovf    <= ovf_next;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_absmax_sum_stream.sv
// Scoreboard bench: stimulus pushes hand-computed frame results into per-DUT
// queues; monitors pop and compare whenever a result is handed off.
module tb_absmax_sum_stream;

    typedef struct {
        int absmax;
        int sum;
        int count;
        int ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    res_t exp_a[$];
    res_t exp_s[$];
    res_t exp_w[$];

    // Main instance: N=8, LANES=4, SUMW=16, wrapping
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic [3:0]  a_in_keep = '0;
    logic        a_in_last = 1'b0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [7:0]  a_out_absmax;
    logic [15:0] a_out_sum;
    logic [15:0] a_out_count;
    logic        a_out_ovf;

    // Narrow-sum instances sharing one stimulus: SUMW=9 saturating / wrapping
    logic        b_in_valid = 1'b0;
    logic [31:0] b_in_data = '0;
    logic [3:0]  b_in_keep = '0;
    logic        b_in_last = 1'b0;
    logic        b_out_ready = 1'b1;
    logic        s_in_ready, w_in_ready;
    logic        s_out_valid, w_out_valid;
    logic [7:0]  s_out_absmax, w_out_absmax;
    logic [8:0]  s_out_sum, w_out_sum;
    logic [15:0] s_out_count, w_out_count;
    logic        s_out_ovf, w_out_ovf;

    absmax_sum_stream #(.N(8), .LANES(4), .SUMW(16), .CNTW(16), .SAT(1'b0)) u_main (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_keep(a_in_keep), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_absmax(a_out_absmax),
        .out_sum(a_out_sum), .out_count(a_out_count), .out_ovf(a_out_ovf)
    );

    absmax_sum_stream #(.N(8), .LANES(4), .SUMW(9), .CNTW(16), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(s_in_ready), .in_data(b_in_data),
        .in_keep(b_in_keep), .in_last(b_in_last),
        .out_valid(s_out_valid), .out_ready(b_out_ready), .out_absmax(s_out_absmax),
        .out_sum(s_out_sum), .out_count(s_out_count), .out_ovf(s_out_ovf)
    );

    absmax_sum_stream #(.N(8), .LANES(4), .SUMW(9), .CNTW(16), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(w_in_ready), .in_data(b_in_data),
        .in_keep(b_in_keep), .in_last(b_in_last),
        .out_valid(w_out_valid), .out_ready(b_out_ready), .out_absmax(w_out_absmax),
        .out_sum(w_out_sum), .out_count(w_out_count), .out_ovf(w_out_ovf)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
        logic [31:0] v0, v1, v2, v3;
        v0 = l0; v1 = l1; v2 = l2; v3 = l3;
        return {v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
    endfunction

    task automatic send_a(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        logic took;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = d; a_in_keep = k; a_in_last = l;
        n = 0;
        forever begin
            #1 took = a_in_ready;
            @(posedge clk);
            if (took) break;
            n++;
            if (n > 50) begin
                n_cmp++; n_fail++;
                $display("FAIL a_accept_timeout: in_ready stayed 0, required 1");
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle_a();
        @(negedge clk);
        a_in_valid = 1'b0; a_in_last = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        logic took;
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = d; b_in_keep = k; b_in_last = l;
        n = 0;
        forever begin
            #1 took = s_in_ready && w_in_ready;
            @(posedge clk);
            if (took) break;
            n++;
            if (n > 50) begin
                n_cmp++; n_fail++;
                $display("FAIL b_accept_timeout: in_ready stayed 0, required 1");
                break;
            end
            @(negedge clk);
        end
    endtask

    // Monitors: a hand-off seen settled after the falling edge completes on
    // the following rising edge, so each is compared exactly once.
    always @(negedge clk) begin
        res_t e;
        #2;
        if (rst_n && a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL a_unexpected: result sum=%0d with no expected entry",
                         $signed(a_out_sum));
            end else begin
                e = exp_a.pop_front();
                check("a_absmax", int'(a_out_absmax), e.absmax);
                check("a_sum", int'($signed(a_out_sum)), e.sum);
                check("a_count", int'(a_out_count), e.count);
                check("a_ovf", int'(a_out_ovf), e.ovf);
            end
        end
        if (rst_n && s_out_valid && b_out_ready) begin
            if (exp_s.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL s_unexpected: result sum=%0d with no expected entry",
                         $signed(s_out_sum));
            end else begin
                e = exp_s.pop_front();
                check("sat_absmax", int'(s_out_absmax), e.absmax);
                check("sat_sum", int'($signed(s_out_sum)), e.sum);
                check("sat_count", int'(s_out_count), e.count);
                check("sat_ovf", int'(s_out_ovf), e.ovf);
            end
        end
        if (rst_n && w_out_valid && b_out_ready) begin
            if (exp_w.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL w_unexpected: result sum=%0d with no expected entry",
                         $signed(w_out_sum));
            end else begin
                e = exp_w.pop_front();
                check("wrap_absmax", int'(w_out_absmax), e.absmax);
                check("wrap_sum", int'($signed(w_out_sum)), e.sum);
                check("wrap_count", int'(w_out_count), e.count);
                check("wrap_ovf", int'(w_out_ovf), e.ovf);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", int'(a_out_valid), 0);
        check("rst_out_absmax", int'(a_out_absmax), 0);
        check("rst_out_sum", int'(a_out_sum), 0);
        check("rst_out_count", int'(a_out_count), 0);
        check("rst_out_ovf", int'(a_out_ovf), 0);
        check("rst_in_ready", int'(a_in_ready), 1);
        #9 rst_n = 1'b1;

        // Single-beat frame, with one-cycle latency check
        exp_a.push_back('{7, -1, 1, 0});
        send_a(pk(3, -7, 5, -2), 4'hF, 1'b1);
        #1 check("latency_out_valid", int'(a_out_valid), 1);
        idle_a();

        // Two-beat frame, most negative sample
        exp_a.push_back('{128, -25, 2, 0});
        send_a(pk(-128, 1, 1, 1), 4'hF, 1'b0);
        send_a(pk(10, 20, 30, 40), 4'hF, 1'b1);

        // Lane masking
        exp_a.push_back('{100, 150, 1, 0});
        send_a(pk(100, -120, 50, 60), 4'b0101, 1'b1);
        idle_a();

        // Backpressure: hold a result, pending last beat stalls upstream
        @(negedge clk);
        a_out_ready = 1'b0;
        exp_a.push_back('{5, 5, 1, 0});
        send_a(pk(5, 0, 0, 0), 4'hF, 1'b1);
        exp_a.push_back('{9, -9, 1, 0});
        fork
            send_a(pk(-9, 0, 0, 0), 4'hF, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk);
                    #2;
                    check("stall_in_ready", int'(a_in_ready), 0);
                    check("stall_out_valid", int'(a_out_valid), 1);
                    check("stall_out_sum", int'($signed(a_out_sum)), 5);
                end
                @(negedge clk);
                a_out_ready = 1'b1;
            end
        join
        #1;
        check("b2b_out_valid", int'(a_out_valid), 1);
        check("b2b_out_sum", int'($signed(a_out_sum)), -9);
        idle_a();

        // Reset mid-frame discards the partial frame
        send_a(pk(1, 2, 3, 4), 4'hF, 1'b0);
        send_a(pk(1, 2, 3, 4), 4'hF, 1'b0);
        idle_a();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_sum", int'(a_out_sum), 0);
        check("midrst_out_valid", int'(a_out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #2 check("postrst_out_valid", int'(a_out_valid), 0);
        end
        exp_a.push_back('{1, 4, 1, 0});
        send_a(pk(1, 1, 1, 1), 4'hF, 1'b1);
        idle_a();

        // Narrow sum: positive overflow (saturate vs wrap)
        exp_s.push_back('{127, 255, 3, 1});
        exp_w.push_back('{127, -12, 3, 1});
        send_b(pk(127, 127, 127, 127), 4'hF, 1'b0);
        send_b(pk(127, 127, 127, 127), 4'hF, 1'b0);
        send_b(pk(127, 127, 127, 127), 4'hF, 1'b1);
        // Negative overflow
        exp_s.push_back('{128, -256, 2, 1});
        exp_w.push_back('{128, 0, 2, 1});
        send_b(pk(-128, -128, -128, -128), 4'hF, 1'b0);
        send_b(pk(-128, -128, -128, -128), 4'hF, 1'b1);
        // Accumulators and ovf cleared for the next frame
        exp_s.push_back('{1, 1, 1, 0});
        exp_w.push_back('{1, 1, 1, 0});
        send_b(pk(1, 0, 0, 0), 4'hF, 1'b1);
        @(negedge clk);
        b_in_valid = 1'b0; b_in_last = 1'b0;

        // Drain with a bounded wait
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (exp_a.size() == 0 && exp_s.size() == 0 && exp_w.size() == 0) break;
        end
        #3;
        check("a_queue_left", exp_a.size(), 0);
        check("sat_queue_left", exp_s.size(), 0);
        check("wrap_queue_left", exp_w.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
